risc_run_ctrl: RTL and testbench
================================

// Module: risc_run_ctrl
// PURPOSE
//  AHB-lite slave that sequences one RISC core run: software-triggered start, then run.
//  On program_finish_i it holds the core awake for a programmable drain window, then sleeps it.
//  Completion raises an interrupt. Provides status and a run-cycle counter.
//  Sits on the system AHB next to the core; sleep_o gates the core's reset/clock enable.
// PARAMETERS
//  DRAIN_DEFAULT  8'h80  reset value of the DRAIN register (drain window, in cycles)
//  CNT_W          32     width of the run-cycle counter (<=32)
// PORTS
//  HCLK              in   1   system bus clock, all state on posedge
//  HRESET            in   1   asynchronous, active-high reset
//  HSEL              in   1   AHB slave select
//  HREADYIn          in   1   AHB ready in
//  HTRANS            in   2   AHB transfer type
//  HWRITE            in   1   AHB write
//  HADDR             in   32  AHB address; only [3:2] decoded
//  HWDATA            in   32  AHB write data
//  HREADYOut         out  1   constant 1 (zero wait state)
//  HRESP             out  2   constant OKAY (2'b00)
//  HRDATA            out  32  read data
//  program_finish_i  in   1   core reports program end (level or pulse)
//  sleep_o           out  1   1 = core held asleep
//  irq_o             out  1   completion interrupt (level)
// BEHAVIOUR
//  Reset: state=IDLE, sleep_o=1, irq_o=0, CYCLES=0, DRAIN=DRAIN_DEFAULT, HRDATA=0.
//  AHB: addr phase valid = HSEL & HREADYIn & HTRANS[1]; register valid/HWRITE/HADDR[3:2].
//   Write commits at the posedge ending the data phase, using HWDATA.
//   HRDATA is combinational from the latched addr during the data phase; it is 0 otherwise.
//   Back-to-back transfers are supported; IDLE/BUSY transfers are ignored.
//  Register map:
//   0x0 CTRL    W   bit0=start, bit1=abort; reads 0
//   0x4 STATUS  RW  rd {29'b0,irq_pend,state[1:0]}; wr bit2=1 clears irq_pend (W1C)
//   0x8 DRAIN   RW  [7:0] drain cycles; upper bits read 0
//   0xC CYCLES  RO  cycles spent in RUN, saturates at all-ones; writes ignored
//  FSM (state encoding IDLE=0, RUN=1, DRAIN=2, DONE=3):
//   IDLE/DONE: on start -> RUN, CYCLES cleared to 0.
//   RUN: CYCLES increments every cycle. On program_finish_i=1 -> DRAIN, drain_cnt<=DRAIN.
//   DRAIN: drain_cnt decrements each cycle. When drain_cnt==0 -> DONE and irq_pend<=1.
//    With DRAIN=0, DONE is reached on the cycle after entering DRAIN.
//   abort, from any state -> IDLE. abort+start in the same write: abort wins; irq_pend unchanged.
//  sleep_o is registered: 0 in RUN and DRAIN, 1 in IDLE and DONE.
//   It changes on the same edge as the state.
//   Start write data phase ends at edge E: state=RUN and sleep_o=0 after E.
//  Boundaries:
//   start while in RUN/DRAIN is ignored.
//   program_finish_i outside RUN is ignored.
//   A DRAIN write during DRAIN affects only the next run.
//   irq set and W1C clear in the same cycle: set wins.
//   The CYCLES increment and the start-clear never coincide; start is only accepted outside RUN.
//   HRESET mid-run forces the reset values immediately (asynchronously).
//  irq_o = irq_pend.
// STRUCTURE
//  Package risc_ctrl_pkg holds: state localparams; register offsets (2-bit);
//   HTRANS codes (IDLE/BUSY/NONSEQ/SEQ); HRESP codes (OKAY/ERROR/RETRY/SPLIT).
//  One sub-module, ahb_lite_reg_if: address-phase capture producing wr_en, wr_addr, rd_addr, rd_en.
//  The FSM, counters and register file stay in the top module.
// TESTING
//  1 Reset -> sleep_o=1, irq_o=0; read STATUS=0x0, DRAIN=0x80, CYCLES=0.
//  2 Write CTRL=1, hold finish low for 20 cycles, then pulse finish.
//     -> sleep_o=0 the cycle after the data phase; CYCLES=20.
//     -> sleep_o=1 and irq_o=1 exactly 0x80+1 cycles after finish; STATUS=0x7.
//  3 Write DRAIN=0, start, finish -> DONE and sleep_o=1 one cycle after finish.
//     Write STATUS=0x4 -> irq_o=0.
//  4 In RUN write CTRL=3 -> IDLE, sleep_o=1, no irq.
//     Pulse finish in IDLE -> state stays IDLE.
//  5 Back-to-back NONSEQ write DRAIN=0x10 then read DRAIN -> HRDATA=0x10 in the second data phase.
//     HTRANS=BUSY write -> no register change.
//  6 Assert HRESET mid-DRAIN -> all outputs at reset values before the next edge.
//     After release, DRAIN=0x80.

Source files
------------

// File: rtl/risc_run_ctrl_pkg.sv
// Shared types and constants for the RISC run controller: FSM states,
// register offsets and AHB-lite transfer/response codes.
package risc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Register offsets as decoded from HADDR[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DRAIN  = 2'd2;
  localparam logic [1:0] REG_CYCLES = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

endpackage

// File: rtl/risc_run_ctrl_if.sv
// AHB-lite slave port bundle for the RISC run controller.
interface risc_run_ctrl_if;
  logic        HSEL;
  logic        HREADYIn;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOut;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HREADYIn, HTRANS, HWRITE, HADDR, HWDATA,
    input  HREADYOut, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HREADYIn, HTRANS, HWRITE, HADDR, HWDATA,
    output HREADYOut, HRESP, HRDATA
  );
endinterface

// File: rtl/risc_run_ctrl_reg_if.sv
// AHB-lite address-phase capture: turns a valid address phase into
// write/read strobes and a register offset for the following data phase.
module ahb_lite_reg_if
  import risc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       ready_in,
  input  logic [1:0] trans,
  input  logic       write,
  input  logic [1:0] addr,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic       rd_en,
  output logic [1:0] rd_addr
);

  logic       vld_p0;
  logic       vld_p1;
  logic       write_p1;
  logic [1:0] addr_p1;

  // IDLE and BUSY transfers never open a data phase
  assign vld_p0 = sel && ready_in &&
                  ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

  // Data-phase valid flag; the only piece of this stage that needs reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  // Direction and offset are qualified by vld_p1, so they carry no reset
  always_ff @(posedge clk) begin
    write_p1 <= write;
    addr_p1  <= addr;
  end

  assign wr_en   = vld_p1 && write_p1;
  assign rd_en   = vld_p1 && !write_p1;
  assign wr_addr = addr_p1;
  assign rd_addr = addr_p1;

endmodule

// File: rtl/risc_run_ctrl.sv
// RISC core run sequencer: software start, run until the core reports
// program end, keep it awake for a programmable drain window, then put it
// to sleep and raise a level interrupt. Zero-wait-state AHB-lite slave.
module risc_run_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter logic [7:0] DRAIN_DEFAULT = 8'h80,
  parameter int         CNT_W         = 32
) (
  input  logic            HCLK,
  input  logic            HRESET,
  risc_run_ctrl_if.slave  bus,
  input  logic            program_finish_i,
  output logic            sleep_o,
  output logic            irq_o
);

  logic       wr_en;
  logic       rd_en;
  logic [1:0] wr_addr;
  logic [1:0] rd_addr;

  state_t           state;
  state_t           state_nxt;
  logic             sleep_nxt;
  logic [CNT_W-1:0] cycles;
  logic [7:0]       drain_reg;
  logic [7:0]       drain_cnt;
  logic             irq_pend;
  logic [31:0]      rdata;

  logic wr_ctrl;
  logic abort;
  logic start;
  logic start_ok;
  logic drain_end;
  logic irq_set;
  logic irq_clr;
  logic unused_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  ahb_lite_reg_if u_reg_if (
    .clk      (HCLK),
    .rst      (HRESET),
    .sel      (bus.HSEL),
    .ready_in (bus.HREADYIn),
    .trans    (bus.HTRANS),
    .write    (bus.HWRITE),
    .addr     (bus.HADDR[3:2]),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr)
  );

  // Only HADDR[3:2] and HWDATA[7:0] carry meaning for this block
  assign unused_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA[31:8]};

  // Abort dominates start when both bits arrive in one CTRL write
  assign wr_ctrl   = wr_en && (wr_addr == REG_CTRL);
  assign abort     = wr_ctrl && bus.HWDATA[1];
  assign start     = wr_ctrl && bus.HWDATA[0] && !bus.HWDATA[1];
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign drain_end = (state == ST_DRAIN) && (drain_cnt == 8'd0);
  assign irq_set   = drain_end && !abort;
  assign irq_clr   = wr_en && (wr_addr == REG_STATUS) && bus.HWDATA[2];

  // Next state and the matching sleep level, so both update on one edge
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start)            state_nxt = ST_RUN;
        ST_RUN:           if (program_finish_i) state_nxt = ST_DRAIN;
        ST_DRAIN:         if (drain_cnt == 8'd0) state_nxt = ST_DONE;
        default:          state_nxt = ST_IDLE;
      endcase
    end
    sleep_nxt = !((state_nxt == ST_RUN) || (state_nxt == ST_DRAIN));
  end

  // FSM state and registered sleep output
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      sleep_o <= 1'b1;
    end else begin
      state   <= state_nxt;
      sleep_o <= sleep_nxt;
    end
  end

  // Run-cycle counter, drain window, DRAIN register and interrupt flag
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cycles    <= '0;
      drain_reg <= DRAIN_DEFAULT;
      drain_cnt <= 8'd0;
      irq_pend  <= 1'b0;
    end else begin
      if (start_ok) begin
        cycles <= '0;
      end else if (state == ST_RUN) begin
        cycles <= sat_inc(cycles);
      end

      // The window is snapshotted on entry, so DRAIN writes hit the next run
      if ((state == ST_RUN) && program_finish_i) begin
        drain_cnt <= drain_reg;
      end else if ((state == ST_DRAIN) && (drain_cnt != 8'd0)) begin
        drain_cnt <= drain_cnt - 8'd1;
      end

      if (wr_en && (wr_addr == REG_DRAIN)) begin
        drain_reg <= bus.HWDATA[7:0];
      end

      if (irq_set) begin
        irq_pend <= 1'b1;
      end else if (irq_clr) begin
        irq_pend <= 1'b0;
      end
    end
  end

  // Read data is driven only during a read data phase
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (rd_addr)
        REG_STATUS: rdata[2:0]       = {irq_pend, state};
        REG_DRAIN:  rdata[7:0]       = drain_reg;
        REG_CYCLES: rdata[CNT_W-1:0] = cycles;
        default:    rdata            = '0;
      endcase
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOut = 1'b1;
  assign bus.HRESP     = HRESP_OKAY;
  assign irq_o         = irq_pend;

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Bench for risc_run_ctrl: directed scenarios followed by randomized runs,
// checked against a timestamp-based model of each run.
module tb_risc_run_ctrl;
  import risc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic fin;
  logic sleep;
  logic irq;

  risc_run_ctrl_if bus();

  always #5 clk = ~clk;

  risc_run_ctrl #(.DRAIN_DEFAULT(8'h80), .CNT_W(32)) dut (
    .HCLK             (clk),
    .HRESET           (rst),
    .bus              (bus),
    .program_finish_i (fin),
    .sleep_o          (sleep),
    .irq_o            (irq)
  );

  int checks = 0;
  int passed = 0;
  int tn     = 0;

  // Model: a run is described by the edges at which it started, saw finish
  // and was aborted; everything observable is derived from those numbers.
  bit         started;
  int         s_edge;
  int         f_edge;
  int         a_edge;
  int         d_run;
  int         set_q[$];
  int         clr_q[$];
  logic [7:0] m_drain;

  function automatic int st_at(input int t);
    if (!started) return 0;
    if (a_edge >= 0 && t >= a_edge) return 0;
    if (f_edge < 0 || t < f_edge) return 1;
    if (t <= f_edge + d_run) return 2;
    return 3;
  endfunction

  function automatic int cur_set();
    int se;
    if (!started || f_edge < 0) return -1;
    se = f_edge + d_run + 1;
    if (a_edge >= 0 && a_edge <= se) return -1;
    return se;
  endfunction

  function automatic bit irq_at(input int t);
    int ls;
    int cs;
    ls = -1;
    foreach (set_q[i]) if (set_q[i] <= t && set_q[i] > ls) ls = set_q[i];
    cs = cur_set();
    if (cs >= 0 && cs <= t && cs > ls) ls = cs;
    if (ls < 0) return 1'b0;
    foreach (clr_q[i]) if (clr_q[i] > ls && clr_q[i] <= t) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int cyc_at(input int t);
    int e;
    if (!started) return 0;
    e = t;
    if (f_edge >= 0 && f_edge < e) e = f_edge;
    if (a_edge >= 0 && a_edge < e) e = a_edge;
    return e - s_edge;
  endfunction

  function automatic logic [31:0] status_at(input int t);
    logic [1:0] s;
    s = 2'(st_at(t));
    return {29'h0, irq_at(t), s};
  endfunction

  function automatic void model_reset();
    started = 1'b0;
    s_edge  = 0;
    f_edge  = -1;
    a_edge  = -1;
    d_run   = 0;
    set_q.delete();
    clr_q.delete();
    m_drain = 8'h80;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, tn);
  endtask

  task automatic tick();
    @(posedge clk);
    tn++;
    @(negedge clk);
  endtask

  task automatic idle_bus();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
  endtask

  task automatic addr_phase(input logic [1:0] a, input logic w, input logic [1:0] tr);
    bus.HSEL   = 1'b1;
    bus.HTRANS = tr;
    bus.HWRITE = w;
    bus.HADDR  = {28'h0, a, 2'b00};
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    int st;
    int cs;
    addr_phase(a, 1'b1, HTRANS_NONSEQ);
    tick();
    idle_bus();
    bus.HWDATA = d;
    tick();
    case (a)
      REG_CTRL: begin
        if (d[1]) begin
          if (started && a_edge < 0) a_edge = tn;
        end else if (d[0]) begin
          st = st_at(tn - 1);
          if (st == 0 || st == 3) begin
            cs = cur_set();
            if (cs >= 0) set_q.push_back(cs);
            started = 1'b1;
            s_edge  = tn;
            f_edge  = -1;
            a_edge  = -1;
          end
        end
      end
      REG_STATUS: if (d[2]) clr_q.push_back(tn);
      REG_DRAIN:  m_drain = d[7:0];
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0, HTRANS_NONSEQ);
    tick();
    idle_bus();
    d = bus.HRDATA;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a);
    logic [31:0] v;
    logic [31:0] e;
    bus_read(a, v);
    case (a)
      REG_STATUS: e = status_at(tn);
      REG_DRAIN:  e = {24'h0, m_drain};
      REG_CYCLES: e = 32'(cyc_at(tn));
      default:    e = 32'h0;
    endcase
    check(tag, v, e);
  endtask

  task automatic check_pins(input string tag);
    int st;
    st = st_at(tn);
    check({tag, "_sleep"}, {31'h0, sleep}, (st == 1 || st == 2) ? 32'd0 : 32'd1);
    check({tag, "_irq"}, {31'h0, irq}, {31'h0, irq_at(tn)});
  endtask

  task automatic pulse_finish();
    fin = 1'b1;
    tick();
    fin = 1'b0;
    if (st_at(tn - 1) == 1 && f_edge < 0) begin
      f_edge = tn;
      d_run  = int'(m_drain);
    end
  endtask

  initial begin
    logic [31:0] v;
    int d;
    int l;
    int mode;

    rst        = 1'b1;
    fin        = 1'b0;
    bus.HREADYIn = 1'b1;
    bus.HWDATA = 32'h0;
    idle_bus();
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: reset values
    check("rst_sleep", {31'h0, sleep}, 32'd1);
    check("rst_irq", {31'h0, irq}, 32'd0);
    bus_read(REG_STATUS, v); check("rst_status", v, 32'h0);
    bus_read(REG_DRAIN, v);  check("rst_drain", v, 32'h80);
    bus_read(REG_CYCLES, v); check("rst_cycles", v, 32'h0);

    // 2: full run with the default drain window
    bus_write(REG_CTRL, 32'h1);
    check("start_sleep", {31'h0, sleep}, 32'd0);
    repeat (19) tick();
    pulse_finish();
    bus_read(REG_CYCLES, v);
    check("run20_cycles", v, 32'd20);
    while (tn < f_edge + 128) tick();
    check("drain_last_sleep", {31'h0, sleep}, 32'd0);
    check("drain_last_irq", {31'h0, irq}, 32'd0);
    tick();
    check("done_sleep", {31'h0, sleep}, 32'd1);
    check("done_irq", {31'h0, irq}, 32'd1);
    bus_read(REG_STATUS, v); check("done_status", v, 32'h7);

    // 3: zero drain window, then W1C
    bus_write(REG_DRAIN, 32'h0);
    bus_write(REG_CTRL, 32'h1);
    tick();
    pulse_finish();
    check("d0_fin_sleep", {31'h0, sleep}, 32'd0);
    tick();
    check("d0_done_sleep", {31'h0, sleep}, 32'd1);
    check_reg("d0_status", REG_STATUS);
    bus_write(REG_STATUS, 32'h4);
    check("w1c_irq", {31'h0, irq}, 32'd0);

    // 4: abort during RUN, finish while idle
    bus_write(REG_CTRL, 32'h1);
    repeat (3) tick();
    bus_write(REG_CTRL, 32'h3);
    check("abort_sleep", {31'h0, sleep}, 32'd1);
    check("abort_irq", {31'h0, irq}, 32'd0);
    bus_read(REG_STATUS, v); check("abort_status", v, 32'h0);
    pulse_finish();
    bus_read(REG_STATUS, v); check("idle_fin_status", v, 32'h0);

    // 5: back-to-back write/read, BUSY ignored, CYCLES read-only
    addr_phase(REG_DRAIN, 1'b1, HTRANS_NONSEQ);
    tick();
    bus.HWDATA = 32'h10;
    addr_phase(REG_DRAIN, 1'b0, HTRANS_NONSEQ);
    tick();
    m_drain = 8'h10;
    idle_bus();
    check("b2b_rdata", bus.HRDATA, 32'h10);
    addr_phase(REG_DRAIN, 1'b1, HTRANS_BUSY);
    tick();
    idle_bus();
    bus.HWDATA = 32'h55;
    tick();
    bus_read(REG_DRAIN, v); check("busy_drain", v, 32'h10);
    bus_write(REG_CYCLES, 32'h1234);
    check_reg("ro_cycles", REG_CYCLES);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      bus_write(REG_DRAIN, 32'(d));
      if ($urandom_range(0, 3) == 0) begin
        pulse_finish();
        check_reg("idle_fin", REG_STATUS);
      end
      bus_write(REG_CTRL, 32'h1);
      check_pins("start");
      l    = int'($urandom_range(4, 30));
      mode = int'($urandom_range(0, 3));
      while (tn - s_edge < l - 1) begin
        case ($urandom_range(0, 3))
          0: tick();
          1: check_reg("run_cycles", REG_CYCLES);
          2: check_reg("run_status", REG_STATUS);
          default: if (tn - s_edge < l - 2) bus_write(REG_CTRL, 32'h1); else tick();
        endcase
        check_pins("run");
      end
      if (mode == 2) begin
        bus_write(REG_CTRL, 32'($urandom_range(2, 3)));
        check_pins("abort_run");
        check_reg("abort_run_cycles", REG_CYCLES);
        check_reg("abort_run_status", REG_STATUS);
      end else begin
        pulse_finish();
        check_pins("finish");
        if (mode == 3) begin
          bus_write(REG_CTRL, 32'($urandom_range(2, 3)));
          check_pins("abort_drain");
          check_reg("abort_drain_status", REG_STATUS);
        end else begin
          while (tn <= f_edge + d_run + 1) begin
            case ($urandom_range(0, 4))
              0, 1: tick();
              2: check_reg("drain_status", REG_STATUS);
              3: bus_write(REG_STATUS, 32'h4);
              default: bus_write(REG_DRAIN, 32'($urandom_range(0, 12)));
            endcase
            check_pins("drain");
          end
          check_reg("end_cycles", REG_CYCLES);
          check_reg("end_status", REG_STATUS);
        end
      end
      bus_write(REG_STATUS, $urandom);
      check_pins("post");
    end

    // 6: asynchronous reset in the middle of DRAIN
    bus_write(REG_DRAIN, 32'h0);
    bus_write(REG_CTRL, 32'h1);
    pulse_finish();
    tick();
    bus_write(REG_DRAIN, 32'h20);
    bus_write(REG_CTRL, 32'h1);
    repeat (4) tick();
    pulse_finish();
    repeat (3) tick();
    check_pins("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("arst_sleep", {31'h0, sleep}, 32'd1);
    check("arst_irq", {31'h0, irq}, 32'd0);
    check("arst_rdata", bus.HRDATA, 32'h0);
    model_reset();
    @(posedge clk);
    tn++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus_read(REG_DRAIN, v);  check("rel_drain", v, 32'h80);
    bus_read(REG_STATUS, v); check("rel_status", v, 32'h0);
    bus_read(REG_CYCLES, v); check("rel_cycles", v, 32'h0);
    check_pins("rel");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
